flow_logic_param: RTL and testbench
===================================

FLOW_LOGIC_PARAM -- requirements
Module: flow_logic_param

Interface
REQ-001 Parameters, one per line: DATA_W, default 6, word width; NUM_CH, default 4, number of destination FIFOs (power of 2, >=2); DEPTH, default 8, words per FIFO (power of 2); CH_W = clog2(NUM_CH); CNT_W = clog2(DEPTH)+1.
REQ-002 Ports, one per line: clk in 1, single clock, rising edge; reset in 1, asynchronous, active-high; init in 1, threshold-load control; wr_enable in 1, write strobe; data_in in DATA_W, word whose top CH_W bits select the destination; pop in NUM_CH, per-channel read strobe; umbral_hi in CNT_W, almost-full threshold; umbral_lo in CNT_W, almost-empty threshold; data_out out NUM_CH*DATA_W, channel i occupies bits [i*DATA_W +: DATA_W]; valid_out out NUM_CH, data_out lane valid; empty out NUM_CH; almost_full out NUM_CH; almost_empty out NUM_CH; error out NUM_CH, sticky per-channel fault; pause_out out 1; idle_out out 1; active_out out 1; error_out out 1; state_out out 3.

Function
REQ-003 FSM states SHALL be RESET, INIT, IDLE, ACTIVE, ERROR; state_out SHALL show the encoding.
REQ-004 RESET SHALL go to INIT on the first clk edge after reset deasserts.
REQ-005 INIT: while init=0, stay in INIT; on an edge with init=1, latch umbral_hi/umbral_lo and go to IDLE.
REQ-006 IDLE goes to ACTIVE when any FIFO is non-empty after the edge; ACTIVE goes to IDLE when all FIFOs are empty after the edge.
REQ-007 IDLE with init=0 SHALL return to INIT; ACTIVE ignores init.
REQ-008 Any fault (push to a full FIFO without a same-cycle pop of that FIFO, or pop of an empty FIFO) SHALL set error[i] and move to ERROR on that edge from IDLE or ACTIVE.
REQ-009 ERROR SHALL be held until reset; all FIFO contents, counts and outputs are frozen, and valid_out SHALL be 0.
REQ-010 Writes SHALL be accepted only in IDLE or ACTIVE; wr_enable is ignored in RESET, INIT and ERROR. Pops SHALL follow the same rule.
REQ-011 Destination SHALL be data_in[DATA_W-1 -: CH_W]; the full DATA_W word is stored.
REQ-012 Pop SHALL be registered: the word appears on data_out lane i with valid_out[i]=1 one cycle after the pop edge; data_out holds its last value otherwise.
REQ-013 Simultaneous push and pop on the same FIFO SHALL be legal even when full: count is unchanged and order is preserved. Pop on an empty FIFO with a same-cycle push is an underflow; there is no bypass.
REQ-014 Counts SHALL be CNT_W bits, range 0..DEPTH; pointers wrap modulo DEPTH.
REQ-015 almost_full[i] = (count_i >= umbral_hi latched); almost_empty[i] = (count_i <= umbral_lo latched); empty[i] = (count_i == 0). All are registered from the post-edge count.
REQ-016 pause_out SHALL be the OR of almost_full. It is advisory only; writes are still accepted while not full.
REQ-017 idle_out=1 only in IDLE, active_out=1 only in ACTIVE, error_out=1 only in ERROR.

Reset
REQ-018 Asserting reset SHALL immediately force: state RESET, pointers and counts 0, data_out 0, valid_out 0, error 0, pause_out 0, empty all 1, almost_empty all 1, almost_full 0, and latched thresholds 0.
REQ-019 Reset mid-operation SHALL discard all queued data, with no residual outputs after release.

Structure
REQ-020 The state encoding and clog2 helper SHALL live in the shared flow_logic package or include.
REQ-021 Each channel SHALL be one instance of sub-module fifo_umbral (DATA_W, DEPTH), which provides push, pop, data, count, empty and full. The top level holds the FSM, routing demux and flags.

Verification
REQ-022 Reset, then init=1 with hi=6 and lo=1 -> INIT to IDLE in 1 cycle; idle_out=1; empty=4'b1111.
REQ-023 Write 6'b010100 -> channel 1 count=1, active_out=1; pop[1] -> next cycle data_out lane1=6'b010100 with valid_out[1]=1, then IDLE.
REQ-024 Write 6 words to channel 0 with hi=6 -> almost_full[0]=1 and pause_out=1; 2 more writes -> full, no error; a 9th write -> error[0]=1, error_out=1, state frozen until reset.
REQ-025 Full channel 3 with simultaneous push and pop -> count stays 8, FIFO order intact, no error.
REQ-026 Pop an empty channel 2 while writing 6'b100010 -> error[2]=1 and ERROR state.
REQ-027 Assert reset with 5 words queued -> all counts 0 and empty=all 1 immediately; after release, INIT waits for init.

Source files
------------

// File: rtl/flow_logic_pkg.sv
// Shared FSM encoding and elaboration helpers for the flow_logic router.
package flow_logic_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/fifo_umbral.sv
// Single-channel circular FIFO; the caller guarantees push/pop legality.
module fifo_umbral
    import flow_logic_pkg::*;
#(
    parameter  int DATA_W = 6,
    parameter  int DEPTH  = 8,
    localparam int PTR_W  = clog2(DEPTH),
    localparam int CNT_W  = clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              empty_o,
    output logic              full_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
        end
    end

    // Storage carries no reset; stale words are never presented as valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/flow_logic_param.sv
// Routes words to NUM_CH FIFOs by their top bits, with threshold flags and a
// control FSM that freezes everything on the first overflow/underflow.
module flow_logic_param
    import flow_logic_pkg::*;
#(
    parameter  int DATA_W = 6,
    parameter  int NUM_CH = 4,
    parameter  int DEPTH  = 8,
    localparam int CH_W   = clog2(NUM_CH),
    localparam int CNT_W  = clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init,
    input  logic                     wr_enable,
    input  logic [DATA_W-1:0]        data_in,
    input  logic [NUM_CH-1:0]        pop,
    input  logic [CNT_W-1:0]         umbral_hi,
    input  logic [CNT_W-1:0]         umbral_lo,
    output logic [NUM_CH*DATA_W-1:0] data_out,
    output logic [NUM_CH-1:0]        valid_out,
    output logic [NUM_CH-1:0]        empty,
    output logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH-1:0]        almost_empty,
    output logic [NUM_CH-1:0]        error,
    output logic                     pause_out,
    output logic                     idle_out,
    output logic                     active_out,
    output logic                     error_out,
    output logic [2:0]               state_out
);

    state_e                         state_q;
    logic [CNT_W-1:0]               hi_q, lo_q, thr_hi, thr_lo;
    logic [NUM_CH-1:0][DATA_W-1:0]  dout_q, fifo_dout;
    logic [NUM_CH-1:0][CNT_W-1:0]   fifo_cnt, cnt_nxt;
    logic [NUM_CH-1:0]              fifo_empty, fifo_full;
    logic [NUM_CH-1:0]              push_req, pop_req, do_push, do_pop, fault;
    logic [NUM_CH-1:0]              valid_q, err_q, empty_q, af_q, ae_q;
    logic [CH_W-1:0]                dest;
    logic                           accept, any_fault, any_busy, upd_flags;

    assign accept = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign dest   = data_in[DATA_W-1 -: CH_W];

    // A fault on any channel blocks every FIFO op on that edge.
    always_comb begin
        push_req = '0;
        pop_req  = '0;
        fault    = '0;
        do_push  = '0;
        do_pop   = '0;
        cnt_nxt  = fifo_cnt;
        any_busy = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            push_req[i] = accept && wr_enable && (dest == CH_W'(i));
            pop_req[i]  = accept && pop[i];
            fault[i]    = (push_req[i] && fifo_full[i] && !pop_req[i]) ||
                          (pop_req[i] && fifo_empty[i]);
        end
        any_fault = |fault;
        if (!any_fault) begin
            do_push = push_req;
            do_pop  = pop_req;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_nxt[i] = fifo_cnt[i] + CNT_W'(do_push[i]) - CNT_W'(do_pop[i]);
            if (cnt_nxt[i] != '0) any_busy = 1'b1;
        end
    end

    assign upd_flags = (accept && !any_fault) || (state_q == ST_INIT && init);
    assign thr_hi    = (state_q == ST_INIT) ? umbral_hi : hi_q;
    assign thr_lo    = (state_q == ST_INIT) ? umbral_lo : lo_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        fifo_umbral #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (do_push[g]),
            .pop_i   (do_pop[g]),
            .din_i   (data_in),
            .dout_o  (fifo_dout[g]),
            .count_o (fifo_cnt[g]),
            .empty_o (fifo_empty[g]),
            .full_o  (fifo_full[g])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RESET;
            hi_q    <= '0;
            lo_q    <= '0;
            dout_q  <= '0;
            valid_q <= '0;
            err_q   <= '0;
            empty_q <= '1;
            ae_q    <= '1;
            af_q    <= '0;
        end else begin
            valid_q <= do_pop;
            for (int i = 0; i < NUM_CH; i++)
                if (do_pop[i]) dout_q[i] <= fifo_dout[i];
            if (accept) err_q <= err_q | fault;
            if (upd_flags) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    empty_q[i] <= (cnt_nxt[i] == '0);
                    af_q[i]    <= (cnt_nxt[i] >= thr_hi);
                    ae_q[i]    <= (cnt_nxt[i] <= thr_lo);
                end
            end
            unique case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    if (init) begin
                        hi_q    <= umbral_hi;
                        lo_q    <= umbral_lo;
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (any_fault)     state_q <= ST_ERROR;
                    else if (!init)    state_q <= ST_INIT;
                    else if (any_busy) state_q <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (any_fault)      state_q <= ST_ERROR;
                    else if (!any_busy) state_q <= ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign data_out     = dout_q;
    assign valid_out    = valid_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign error        = err_q;
    assign pause_out    = |af_q;
    assign idle_out     = (state_q == ST_IDLE);
    assign active_out   = (state_q == ST_ACTIVE);
    assign error_out    = (state_q == ST_ERROR);
    assign state_out    = state_q;

endmodule

// File: tb/tb_flow_logic_param.sv
// Self-checking bench: directed vector table, corner sequences, and random
// traffic compared against a queue-based reference model.
module tb_flow_logic_param;

    localparam int DATA_W = 6;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic                     clk = 1'b0;
    logic                     reset, init, wr_enable;
    logic [DATA_W-1:0]        data_in;
    logic [NUM_CH-1:0]        pop;
    logic [CNT_W-1:0]         umbral_hi, umbral_lo;
    logic [NUM_CH*DATA_W-1:0] data_out;
    logic [NUM_CH-1:0]        valid_out, empty, almost_full, almost_empty, error;
    logic                     pause_out, idle_out, active_out, error_out;
    logic [2:0]               state_out;

    flow_logic_param #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable),
        .data_in(data_in), .pop(pop), .umbral_hi(umbral_hi), .umbral_lo(umbral_lo),
        .data_out(data_out), .valid_out(valid_out), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .error(error),
        .pause_out(pause_out), .idle_out(idle_out), .active_out(active_out),
        .error_out(error_out), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: state as 0..4 (RESET, INIT, IDLE, ACTIVE, ERROR)
    int                  m_state, m_hi, m_lo;
    logic [DATA_W-1:0]   mq [NUM_CH][$];
    logic [23:0]         m_dout;
    logic [NUM_CH-1:0]   m_valid, m_err, m_empty, m_ae, m_af;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = 0; m_hi = 0; m_lo = 0; m_dout = '0;
        m_valid = '0; m_err = '0; m_empty = '1; m_ae = '1; m_af = '0;
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    endtask

    task automatic m_flags();
        for (int c = 0; c < NUM_CH; c++) begin
            m_empty[c] = (mq[c].size() == 0);
            m_af[c]    = (mq[c].size() >= m_hi);
            m_ae[c]    = (mq[c].size() <= m_lo);
        end
    endtask

    task automatic m_step(input bit i_init, input bit i_wr, input logic [5:0] i_din,
                          input logic [3:0] i_pop);
        bit fault;
        bit any;
        int dst;
        fault = 0;
        any = 0;
        dst = int'(i_din[5:4]);
        m_valid = '0;
        case (m_state)
            0: m_state = 1;
            1: if (i_init) begin
                   m_hi = int'(umbral_hi); m_lo = int'(umbral_lo);
                   m_flags();
                   m_state = 2;
               end
            2, 3: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if ((i_wr && dst == c && mq[c].size() == DEPTH && !i_pop[c]) ||
                        (i_pop[c] && mq[c].size() == 0)) begin
                        fault = 1;
                        m_err[c] = 1'b1;
                    end
                end
                if (fault) m_state = 4;
                else begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        if (i_pop[c]) begin
                            m_dout[c*DATA_W +: DATA_W] = mq[c].pop_front();
                            m_valid[c] = 1'b1;
                        end
                        if (i_wr && dst == c) mq[c].push_back(i_din);
                        if (mq[c].size() != 0) any = 1;
                    end
                    m_flags();
                    if (m_state == 2 && !i_init) m_state = 1;
                    else m_state = any ? 3 : 2;
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_model();
        chk("state", 32'(state_out), 32'(m_state));
        chk("data_out", 32'(data_out), 32'(m_dout));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("empty", 32'(empty), 32'(m_empty));
        chk("almost_empty", 32'(almost_empty), 32'(m_ae));
        chk("almost_full", 32'(almost_full), 32'(m_af));
        chk("error", 32'(error), 32'(m_err));
        chk("pause_out", 32'(pause_out), 32'(|m_af));
        chk("state_flags", 32'({idle_out, active_out, error_out}),
            32'({m_state == 2, m_state == 3, m_state == 4}));
    endtask

    task automatic step(input bit i_init, input bit i_wr, input logic [5:0] i_din,
                        input logic [3:0] i_pop);
        init = i_init; wr_enable = i_wr; data_in = i_din; pop = i_pop;
        m_step(i_init, i_wr, i_din, i_pop);
        @(posedge clk);
        @(negedge clk);
        check_model();
    endtask

    // Called at a negedge; reset takes effect without waiting for a clock.
    task automatic do_reset();
        reset = 1'b1; init = 1'b0; wr_enable = 1'b0; pop = '0;
        m_reset();
        #1;
        check_model();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          ini;
        bit          wr;
        logic [5:0]  din;
        logic [3:0]  pp;
        logic [2:0]  st;
        logic [3:0]  vld;
        logic [3:0]  emp;
        logic [3:0]  ae;
        logic [3:0]  af;
        logic [23:0] dout;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] w;
        reset = 1'b1; init = 1'b0; wr_enable = 1'b0; data_in = '0; pop = '0;
        umbral_hi = 4'd6; umbral_lo = 4'd1;

        tbl[0] = '{0, 0, 6'h00,       4'b0000, 3'd1, 4'h0, 4'hF, 4'hF, 4'h0, 24'h0};
        tbl[1] = '{1, 0, 6'h00,       4'b0000, 3'd2, 4'h0, 4'hF, 4'hF, 4'h0, 24'h0};
        tbl[2] = '{1, 1, 6'b010100,   4'b0000, 3'd3, 4'h0, 4'hD, 4'hF, 4'h0, 24'h0};
        tbl[3] = '{1, 0, 6'h00,       4'b0010, 3'd2, 4'h2, 4'hF, 4'hF, 4'h0, 24'h000500};
        tbl[4] = '{1, 0, 6'h00,       4'b0000, 3'd2, 4'h0, 4'hF, 4'hF, 4'h0, 24'h000500};
        tbl[5] = '{0, 0, 6'h00,       4'b0000, 3'd1, 4'h0, 4'hF, 4'hF, 4'h0, 24'h000500};

        do_reset();
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_empty", 32'(empty), 32'hF);
        for (int k = 0; k < 6; k++) begin
            step(tbl[k].ini, tbl[k].wr, tbl[k].din, tbl[k].pp);
            chk($sformatf("tbl%0d_state", k), 32'(state_out), 32'(tbl[k].st));
            chk($sformatf("tbl%0d_valid", k), 32'(valid_out), 32'(tbl[k].vld));
            chk($sformatf("tbl%0d_empty", k), 32'(empty), 32'(tbl[k].emp));
            chk($sformatf("tbl%0d_ae", k), 32'(almost_empty), 32'(tbl[k].ae));
            chk($sformatf("tbl%0d_af", k), 32'(almost_full), 32'(tbl[k].af));
            chk($sformatf("tbl%0d_dout", k), 32'(data_out), 32'(tbl[k].dout));
        end

        // Channel 0 fill: thresholds, full without fault, then overflow
        step(1, 0, 6'h00, 4'b0000);
        for (int k = 0; k < 6; k++) step(1, 1, {2'b00, 4'(k)}, 4'b0000);
        chk("ovf_af0", 32'(almost_full[0]), 32'd1);
        chk("ovf_pause", 32'(pause_out), 32'd1);
        for (int k = 6; k < 8; k++) step(1, 1, {2'b00, 4'(k)}, 4'b0000);
        chk("ovf_full_noerr", 32'(error), 32'd0);
        step(1, 1, 6'h0F, 4'b0000);
        chk("ovf_err0", 32'(error), 32'h1);
        chk("ovf_error_out", 32'(error_out), 32'd1);
        chk("ovf_state", 32'(state_out), 32'd4);
        step(1, 1, 6'h01, 4'b0001);
        step(0, 0, 6'h00, 4'b0001);
        chk("frozen_state", 32'(state_out), 32'd4);
        chk("frozen_valid", 32'(valid_out), 32'd0);
        do_reset();

        // Channel 3 full with simultaneous push/pop keeps count and order
        step(0, 0, 6'h00, 4'b0000);
        step(1, 0, 6'h00, 4'b0000);
        for (int k = 0; k < 8; k++) step(1, 1, {2'b11, 4'(k)}, 4'b0000);
        step(1, 1, {2'b11, 4'd8}, 4'b1000);
        chk("pp_err", 32'(error), 32'd0);
        chk("pp_state", 32'(state_out), 32'd3);
        chk("pp_af3", 32'(almost_full[3]), 32'd1);
        chk("pp_lane3", 32'(data_out[18 +: 6]), 32'h30);
        for (int k = 1; k <= 8; k++) begin
            step(1, 0, 6'h00, 4'b1000);
            w = {2'b11, 4'(k)};
            chk($sformatf("pp_order%0d", k), 32'(data_out[18 +: 6]), 32'(w));
        end
        chk("pp_drained", 32'(state_out), 32'd2);

        // Underflow on channel 2 despite a same-cycle write to it
        step(1, 1, 6'b100010, 4'b0100);
        chk("unf_err2", 32'(error), 32'h4);
        chk("unf_state", 32'(state_out), 32'd4);
        do_reset();

        // Reset with words queued
        step(0, 0, 6'h00, 4'b0000);
        step(1, 0, 6'h00, 4'b0000);
        for (int k = 0; k < 5; k++) step(1, 1, {2'(k), 4'(k + 1)}, 4'b0000);
        do_reset();
        chk("mid_rst_empty", 32'(empty), 32'hF);
        chk("mid_rst_state", 32'(state_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 6'h00, 4'b0000);
            chk("post_rst_init", 32'(state_out), 32'd1);
        end

        // Random traffic against the model
        umbral_hi = 4'($urandom_range(1, 8));
        umbral_lo = 4'($urandom_range(0, 7));
        for (int n = 0; n < 600; n++) begin
            logic [3:0] p;
            if (m_state == 4) begin
                do_reset();
                umbral_hi = 4'($urandom_range(1, 8));
                umbral_lo = 4'($urandom_range(0, 7));
            end
            p = '0;
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 2) == 0 && (mq[c].size() > 0 || $urandom_range(0, 80) == 0))
                    p[c] = 1'b1;
            step($urandom_range(0, 39) != 0, $urandom_range(0, 2) != 0, 6'($urandom), p);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
